scope_capture_ctrl: RTL and testbench
=====================================

Name: scope_capture_ctrl

Overview:
- Sequences oscilloscope sample capture into a two-bank (ping-pong) line buffer and schedules bank hand-off to the VGA renderer.
- Sits between the ADC sample stream and the frame/line buffer read by the VGA pixel pipeline (vga_hsync/vga_vsync/R/G/B path).
- Arms on a trigger condition and writes DEPTH samples into the back bank. It swaps banks only at the start of a vertical sync pulse, so the display never tears.

Parameters:
- DATA_W, 8, sample and trigger-level width (unsigned).
- DEPTH, 640, samples per capture (one per visible pixel column).
- ADDR_W, 10, sample address width; DEPTH <= 2**ADDR_W.
- AUTO_TIMEOUT, 100000, cycles in ARM before a forced trigger (AUTO_TRIG_EN only).

Ports:
- clock, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous active-high reset.
- run, input, 1, level: 1 = continuous capture; 0 = stop after the current frame.
- trig_slope, input, 1, 0 = rising-edge trigger, 1 = falling-edge trigger.
- trig_level, input, DATA_W, trigger threshold.
- sample_valid, input, 1, a new sample is present this cycle.
- sample, input, DATA_W, ADC sample.
- vga_vsync, input, 1, VGA vertical sync (active-low), from the timing generator.
- wr_en, output, 1, buffer write strobe.
- wr_addr, output, ADDR_W+1, {bank, index}; the MSB is the back bank.
- wr_data, output, DATA_W, sample being written.
- disp_bank, output, 1, bank the renderer reads.
- capturing, output, 1, high in the CAPTURE state.
- frame_swapped, output, 1, one-cycle pulse when disp_bank toggles.

Behaviour:
- Reset values:
  - state = IDLE; wr_en, wr_addr, wr_data, capturing and frame_swapped = 0; disp_bank = 0.
  - prev_sample = 0, prev_valid = 0.
  - The vsync edge register is loaded with 1 (inactive).
- Reset mid-operation aborts any capture. The partially written back bank is not displayed.
- Back bank = ~disp_bank.
- Write path:
  - Registered; wr_en/wr_addr/wr_data appear 1 cycle after the qualifying sample_valid.
  - wr_en is high for exactly one cycle per written sample.
- Trigger condition (evaluated only on cycles with sample_valid = 1 and prev_valid = 1):
  - Rising: prev_sample < trig_level and sample >= trig_level.
  - Falling: prev_sample > trig_level and sample <= trig_level.
  - prev_sample and prev_valid update on every sample_valid, in every state.
- States:
  - IDLE: no writes. When run = 1, go to ARM and clear prev_valid.
  - ARM:
    - If run = 0, return to IDLE.
    - On the trigger condition, go to CAPTURE. The trigger sample is written at index 0, and idx becomes 1.
  - CAPTURE:
    - Each sample_valid writes the sample at idx, then idx increments.
    - Cycles without sample_valid stall the index; there is no timeout.
    - Writing index DEPTH-1 moves the block to WAIT_VB. The index does not wrap.
    - run = 0 here does not abort; the capture completes.
  - WAIT_VB:
    - Waits for a vga_vsync falling edge (registered prev = 1, current = 0) detected while in this state.
    - On the edge: toggle disp_bank, pulse frame_swapped, go to ARM if run = 1, else IDLE.
    - A vsync edge in the same cycle as the DEPTH-1 write belongs to CAPTURE and is ignored; the swap waits for the next edge.
    - Samples arriving in WAIT_VB are not written.
- Back-to-back frames: the re-entry to ARM clears prev_valid. A new trigger therefore needs two fresh samples.
- Edge cases:
  - trig_level = 0 rising: the condition needs prev < 0, so it can never fire without AUTO_TRIG_EN.
  - trig_level = max falling: the condition needs prev > max, so it likewise can never fire.
  - Both cases are legal and must not lock up the reset path.

Optional Feature:
- AUTO_TRIG_EN:
  - When defined, a counter runs while in ARM and clears on entry to ARM.
  - When the counter reaches AUTO_TIMEOUT-1, the next sample_valid forces the trigger (free-running display).
- When not defined, ARM waits indefinitely and no counter is synthesized.

Test Plan:
- Reset then run = 1, rising trigger, trig_level = 0x80; ramp 0x70..0xFF then wrap, one sample per cycle:
  - First write is wr_addr = {1, 0}, wr_data = 0x80.
  - 640 consecutive wr_en pulses follow; the last is at index 639.
- Capture complete, then drive vga_vsync 1 -> 0:
  - disp_bank becomes 1 and frame_swapped pulses for exactly 1 cycle.
  - The next capture writes bank 0.
- Falling trigger, level = 0x40, samples 0x50, 0x40: triggers on 0x40. Samples 0x40, 0x30 must not trigger.
- sample_valid asserted every 3rd cycle during CAPTURE: the index advances only on valid samples, with no gaps and no duplicate addresses.
- run = 0 in mid-CAPTURE: capture finishes at 639, the swap occurs on the next vsync falling edge, then the block stays in IDLE with no further wr_en.
- reset at index 300: all outputs return to reset values and disp_bank = 0. With AUTO_TRIG_EN defined, AUTO_TIMEOUT = 50 and a constant 0x10 input, a forced capture starts on the first valid sample after 50 ARM cycles.

Source files
------------

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture sequencer: triggers, fills the back bank of a ping-pong line buffer
// and swaps banks on a vsync falling edge. Optional forced trigger under `AUTO_TRIG_EN.
module scope_capture_ctrl #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              trig_slope,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              vga_vsync,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              disp_bank,
  output logic              capturing,
  output logic              frame_swapped
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, WAIT_VB} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   idx, idx_d;
  logic                disp_bank_d;
  logic                swap_d;
  logic                wr_en_d;
  logic [ADDR_W:0]     wr_addr_d;
  logic [DATA_W-1:0]   prev_sample;
  logic                prev_valid, prev_valid_d;
  logic                vsync_p1;
  logic                vsync_fall;
  logic                enter_arm;
  logic                force_trig;
  logic                trig_hit;

  function automatic logic level_crossed(input logic              slope,
                                         input logic [DATA_W-1:0] prev,
                                         input logic [DATA_W-1:0] cur,
                                         input logic [DATA_W-1:0] lvl);
    if (slope) return (prev > lvl) && (cur <= lvl);
    else       return (prev < lvl) && (cur >= lvl);
  endfunction

`ifdef AUTO_TRIG_EN
  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TIMEOUT - 1);

  logic [CNT_W-1:0] arm_cnt;

  // Saturates at the last count so the forced trigger stays pending until a sample arrives.
  always_ff @(posedge clock) begin
    if (reset || enter_arm || state != ARM) arm_cnt <= '0;
    else if (arm_cnt != CNT_LAST)           arm_cnt <= arm_cnt + CNT_W'(1);
  end

  assign force_trig = (arm_cnt == CNT_LAST);
`else
  assign force_trig = 1'b0;
`endif

  assign vsync_fall = vsync_p1 & ~vga_vsync;
  assign trig_hit   = sample_valid &&
                      ((prev_valid && level_crossed(trig_slope, prev_sample, sample, trig_level)) ||
                       force_trig);
  assign capturing  = (state == CAPTURE);

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    disp_bank_d = disp_bank;
    swap_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = {~disp_bank, idx};
    enter_arm   = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_d   = ARM;
          enter_arm = 1'b1;
        end
      end
      ARM: begin
        if (!run) begin
          state_d = IDLE;
        end else if (trig_hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~disp_bank, {ADDR_W{1'b0}}};
          idx_d     = ADDR_W'(1);
          state_d   = (DEPTH == 1) ? WAIT_VB : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          wr_en_d = 1'b1;
          if (idx == LAST_IDX) state_d = WAIT_VB;
          else                 idx_d   = idx + ADDR_W'(1);
        end
      end
      WAIT_VB: begin
        if (vsync_fall) begin
          disp_bank_d = ~disp_bank;
          swap_d      = 1'b1;
          if (run) begin
            state_d   = ARM;
            enter_arm = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Fresh arming discards history so a trigger needs two new samples.
    if (enter_arm)         prev_valid_d = 1'b0;
    else if (sample_valid) prev_valid_d = 1'b1;
    else                   prev_valid_d = prev_valid;
  end

  // Registered write port and control state
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      disp_bank     <= 1'b0;
      prev_sample   <= '0;
      prev_valid    <= 1'b0;
      vsync_p1      <= 1'b1;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_swapped <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      disp_bank     <= disp_bank_d;
      prev_valid    <= prev_valid_d;
      vsync_p1      <= vga_vsync;
      wr_en         <= wr_en_d;
      frame_swapped <= swap_d;
      if (sample_valid) prev_sample <= sample;
      if (wr_en_d) begin
        wr_addr <= wr_addr_d;
        wr_data <= sample;
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: capture, bank swap, falling trigger, stalls,
// stop-after-frame, mid-capture reset and (with AUTO_TRIG_EN) the forced trigger.
module tb_scope_capture_ctrl;

`ifdef AUTO_TRIG_EN
  localparam int TB_AUTO = 50;
`else
  localparam int TB_AUTO = 100000;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        trig_slope;
  logic [7:0]  trig_level;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        vga_vsync;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        disp_bank;
  logic        capturing;
  logic        frame_swapped;

  int tests = 0;
  int fails = 0;

  scope_capture_ctrl #(
    .DATA_W(8), .DEPTH(640), .ADDR_W(10), .AUTO_TIMEOUT(TB_AUTO)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .trig_slope(trig_slope),
    .trig_level(trig_level), .sample_valid(sample_valid), .sample(sample),
    .vga_vsync(vga_vsync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .capturing(capturing), .frame_swapped(frame_swapped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int gaps;
    int first_i;
    int writes;
    logic [7:0] fall_s [4];
    logic       fall_e [4];

    reset = 1'b1; run = 1'b0; trig_slope = 1'b0; trig_level = 8'h80;
    sample_valid = 1'b0; sample = 8'h00; vga_vsync = 1'b1;
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_swapped", frame_swapped, 0);
    chk("rst_disp_bank", disp_bank, 0);

    // Rising trigger at 0x80 on a ramp starting at 0x70: full capture into bank 1
    reset = 1'b0; run = 1'b1;
    tick();
    chk("arm_capturing", capturing, 0);
    n = 0; gaps = 0; first_i = -1;
    for (int i = 0; i < 670; i++) begin
      sample = 8'(8'h70 + i); sample_valid = 1'b1;
      tick();
      if (wr_en) begin
        if (n == 0) first_i = i;
        chk("b_addr", wr_addr, {1'b1, 10'(n)});
        chk("b_data", wr_data, 8'(8'h80 + n));
        n++;
      end else if (n > 0 && n < 640) begin
        gaps++;
      end
    end
    chk("b_count", n, 640);
    chk("b_first", first_i, 16);
    chk("b_gaps", gaps, 0);
    chk("b_capturing", capturing, 0);
    chk("b_disp_bank", disp_bank, 0);

    // vsync falling edge swaps banks with a single-cycle pulse
    sample_valid = 1'b0; vga_vsync = 1'b0;
    tick();
    chk("c_disp_bank", disp_bank, 1);
    chk("c_swapped", frame_swapped, 1);
    tick();
    chk("c_swapped_end", frame_swapped, 0);
    chk("c_disp_bank_hold", disp_bank, 1);

    // Next capture goes to bank 0; reset it at index 300
    n = 0;
    for (int i = 0; i < 400 && n < 300; i++) begin
      sample = 8'(8'h70 + i); sample_valid = 1'b1;
      tick();
      if (wr_en) begin
        if (n == 0) begin
          chk("d_first_addr", wr_addr, 11'h000);
          chk("d_first_data", wr_data, 8'h80);
        end
        n++;
      end
    end
    chk("d_count", n, 300);
    chk("d_capturing", capturing, 1);
    reset = 1'b1; run = 1'b0; vga_vsync = 1'b1;
    tick();
    chk("d_rst_wr_en", wr_en, 0);
    chk("d_rst_wr_addr", wr_addr, 0);
    chk("d_rst_wr_data", wr_data, 0);
    chk("d_rst_capturing", capturing, 0);
    chk("d_rst_swapped", frame_swapped, 0);
    chk("d_rst_disp_bank", disp_bank, 0);
    reset = 1'b0;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      sample = 8'(8'h78 + i); sample_valid = 1'b1;
      tick();
      if (wr_en) writes++;
    end
    chk("d_idle_writes", writes, 0);

    // Falling trigger at 0x40: 0x40,0x30 and 0x30,0x50 do not fire, 0x50,0x40 does
    run = 1'b1; trig_slope = 1'b1; trig_level = 8'h40; sample_valid = 1'b0;
    tick();
    fall_s = '{8'h40, 8'h30, 8'h50, 8'h40};
    fall_e = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sample = fall_s[i]; sample_valid = 1'b1;
      tick();
      chk("e_wr_en", wr_en, fall_e[i]);
    end
    chk("e_addr", wr_addr, 11'h400);
    chk("e_data", wr_data, 8'h40);
    chk("e_capturing", capturing, 1);

    // One valid sample every third cycle; run drops mid-frame; vsync falls with the last write
    for (int k = 1; k < 640; k++) begin
      sample = 8'(k) ^ 8'h5A; sample_valid = 1'b1;
      if (k == 300) run = 1'b0;
      if (k == 639) vga_vsync = 1'b0;
      tick();
      chk("f_wr_en", wr_en, 1);
      chk("f_addr", wr_addr, {1'b1, 10'(k)});
      chk("f_data", wr_data, 8'(k) ^ 8'h5A);
      if (k == 300) chk("f_capturing", capturing, 1);
      sample_valid = 1'b0;
      tick();
      chk("f_stall1", wr_en, 0);
      tick();
      chk("f_stall2", wr_en, 0);
    end
    chk("f_done_capturing", capturing, 0);
    chk("f_no_early_swap", disp_bank, 0);
    chk("f_no_early_pulse", frame_swapped, 0);
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      sample = 8'(8'h50 - 8 * i); sample_valid = 1'b1;
      tick();
      if (wr_en) writes++;
    end
    sample_valid = 1'b0;
    chk("g_waitvb_writes", writes, 0);
    chk("g_disp_bank_hold", disp_bank, 0);
    vga_vsync = 1'b1;
    tick();
    chk("g_rise_no_swap", frame_swapped, 0);
    vga_vsync = 1'b0;
    tick();
    chk("g_disp_bank", disp_bank, 1);
    chk("g_swapped", frame_swapped, 1);
    tick();
    chk("g_swapped_end", frame_swapped, 0);
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      sample = (i % 2 == 0) ? 8'h50 : 8'h30; sample_valid = 1'b1;
      tick();
      if (wr_en) writes++;
    end
    chk("g_idle_writes", writes, 0);
    chk("g_idle_capturing", capturing, 0);

`ifdef AUTO_TRIG_EN
    // Constant input never crosses the level; the timeout forces the capture
    sample_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b1; trig_slope = 1'b0; trig_level = 8'h80; sample = 8'h10;
    tick();
    first_i = -1;
    for (int j = 1; j <= 60; j++) begin
      sample_valid = 1'b1;
      tick();
      if (wr_en && first_i < 0) begin
        first_i = j;
        chk("h_addr", wr_addr, 11'h400);
        chk("h_data", wr_data, 8'h10);
      end
    end
    chk("h_first_cycle", first_i, 50);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
